// File: rtl/leds_racer_race_ctrl.sv
// Race controller for the LED racer game. It runs the idle/countdown/race/finish flow and
// hands position snapshots to the LED frame streamer over a req/ack handshake.
module leds_racer_race_ctrl #(
    parameter int MAX_POS      = 109,
    parameter int COUNT_CYCLES = 50000000,
    localparam int PW          = $clog2(MAX_POS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    press,
    input  logic          force_reset,
    input  logic          frame_ack,
    output logic          frame_req,
    output logic [PW-1:0] pos_blue,
    output logic [PW-1:0] pos_red,
    output logic [PW-1:0] pos_green,
    output logic [PW-1:0] pos_yellow,
    output logic [1:0]    game_state,
    output logic [1:0]    winner,
    output logic          winner_valid
);

    localparam int CW = (COUNT_CYCLES > 1) ? $clog2(COUNT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RACE      = 2'd2,
        FINISH    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pos_q [4];
    logic [PW-1:0]   pos_d [4];
    logic [1:0]      win_q, win_d;
    logic            win_valid_q, win_valid_d;
    logic            dirty_q;
    logic            changed;
    logic            arrived;
    logic            snap;

    logic [PW-1:0]   snap_pos_q [4];
    logic [1:0]      snap_state_q;
    logic [1:0]      snap_win_q;
    logic            snap_win_valid_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        arrived     = 1'b0;
        for (int i = 0; i < 4; i++) pos_d[i] = pos_q[i];

        if (force_reset) begin
            state_d     = IDLE;
            cnt_d       = '0;
            win_d       = 2'd0;
            win_valid_d = 1'b0;
            for (int i = 0; i < 4; i++) pos_d[i] = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|press) begin
                        state_d = COUNTDOWN;
                        cnt_d   = CW'(COUNT_CYCLES - 1);
                    end
                end
                COUNTDOWN: begin
                    if (cnt_q == '0) state_d = RACE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                RACE: begin
                    for (int i = 0; i < 4; i++) begin
                        if (press[i] && (pos_q[i] != PW'(MAX_POS))) pos_d[i] = pos_q[i] + 1'b1;
                    end
                    // Scan from yellow down so the lowest arriving index is the one kept.
                    for (int i = 3; i >= 0; i--) begin
                        if (pos_d[i] == PW'(MAX_POS)) begin
                            arrived = 1'b1;
                            win_d   = 2'(i);
                        end
                    end
                    if (arrived) begin
                        state_d     = FINISH;
                        win_valid_d = 1'b1;
                    end
                end
                FINISH: begin
                    state_d = FINISH;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        changed = force_reset || (state_d != state_q) || (win_d != win_q) ||
                  (win_valid_d != win_valid_q);
        for (int i = 0; i < 4; i++) begin
            if (pos_d[i] != pos_q[i]) changed = 1'b1;
        end
    end

    assign snap = !frame_req && dirty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            win_q            <= 2'd0;
            win_valid_q      <= 1'b0;
            dirty_q          <= 1'b1;
            frame_req        <= 1'b0;
            snap_state_q     <= 2'd0;
            snap_win_q       <= 2'd0;
            snap_win_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pos_q[i]      <= '0;
                snap_pos_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            for (int i = 0; i < 4; i++) pos_q[i] <= pos_d[i];

            // A change on a snapshot edge keeps dirty set, so a follow-up frame is requested.
            if (changed)   dirty_q <= 1'b1;
            else if (snap) dirty_q <= 1'b0;

            if (snap) begin
                frame_req        <= 1'b1;
                snap_state_q     <= state_q;
                snap_win_q       <= win_q;
                snap_win_valid_q <= win_valid_q;
                for (int i = 0; i < 4; i++) snap_pos_q[i] <= pos_q[i];
            end else if (frame_req && frame_ack) begin
                frame_req <= 1'b0;
            end
        end
    end

    assign pos_blue     = snap_pos_q[0];
    assign pos_red      = snap_pos_q[1];
    assign pos_green    = snap_pos_q[2];
    assign pos_yellow   = snap_pos_q[3];
    assign game_state   = snap_state_q;
    assign winner       = snap_win_q;
    assign winner_valid = snap_win_valid_q;

endmodule

// File: tb/tb_leds_racer_race_ctrl.sv
// Directed bench for leds_racer_race_ctrl with a short track and countdown.
module tb_leds_racer_race_ctrl;

    localparam int MAX_POS      = 5;
    localparam int COUNT_CYCLES = 4;
    localparam int PW           = $clog2(MAX_POS + 1);
    localparam int NV           = 27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    press = 4'd0;
    logic          force_reset = 1'b0;
    logic          frame_ack = 1'b0;
    logic          frame_req;
    logic [PW-1:0] pos_blue, pos_red, pos_green, pos_yellow;
    logic [1:0]    game_state, winner;
    logic          winner_valid;

    int n_pass  = 0;
    int n_total = 0;

    leds_racer_race_ctrl #(.MAX_POS(MAX_POS), .COUNT_CYCLES(COUNT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .press(press), .force_reset(force_reset),
        .frame_ack(frame_ack), .frame_req(frame_req),
        .pos_blue(pos_blue), .pos_red(pos_red), .pos_green(pos_green),
        .pos_yellow(pos_yellow), .game_state(game_state), .winner(winner),
        .winner_valid(winner_valid)
    );

    always #5 clk = ~clk;

    // {frame_req, pos_blue, pos_red, pos_green, pos_yellow, game_state, winner, winner_valid}
    typedef logic [1+4*PW+2+2+1-1:0] obs_t;

    typedef struct {
        logic [3:0] press;
        logic       frc;
        logic       ack;
        obs_t       exp;
    } vec_t;

    vec_t vecs [NV];

    function automatic obs_t pk(input logic r, input int pb, input int pr, input int pg,
                                input int py, input int gs, input int w, input logic wv);
        return {r, PW'(pb), PW'(pr), PW'(pg), PW'(py), 2'(gs), 2'(w), wv};
    endfunction

    function automatic vec_t mk(input logic [3:0] p, input logic f, input logic a, input obs_t e);
        vec_t v;
        v.press = p;
        v.frc   = f;
        v.ack   = a;
        v.exp   = e;
        return v;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = {frame_req, pos_blue, pos_red, pos_green, pos_yellow, game_state, winner, winner_valid};
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (req,pb,pr,pg,py,gs,w,wv)", name, act, exp);
        else
            n_pass++;
    endtask

    // Called at a falling edge: inputs hold across the next rising edge, then clear.
    task automatic cycle(input logic [3:0] p, input logic f, input logic a);
        press       = p;
        force_reset = f;
        frame_ack   = a;
        @(negedge clk);
        press       = 4'd0;
        force_reset = 1'b0;
        frame_ack   = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(4'h0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(4'h0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs[2]  = mk(4'h0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs[3]  = mk(4'h0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[4]  = mk(4'h0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[5]  = mk(4'h1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[6]  = mk(4'h1, 0, 0, pk(1, 0, 0, 0, 0, 1, 0, 0));
        vecs[7]  = mk(4'h2, 0, 1, pk(0, 0, 0, 0, 0, 1, 0, 0));
        vecs[8]  = mk(4'h0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 0));
        vecs[9]  = mk(4'h0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 0));
        vecs[10] = mk(4'h0, 0, 0, pk(1, 0, 0, 0, 0, 2, 0, 0));
        vecs[11] = mk(4'h1, 0, 0, pk(1, 0, 0, 0, 0, 2, 0, 0));
        vecs[12] = mk(4'h1, 0, 0, pk(1, 0, 0, 0, 0, 2, 0, 0));
        vecs[13] = mk(4'h1, 0, 0, pk(1, 0, 0, 0, 0, 2, 0, 0));
        vecs[14] = mk(4'h0, 0, 1, pk(0, 0, 0, 0, 0, 2, 0, 0));
        vecs[15] = mk(4'h0, 0, 0, pk(1, 3, 0, 0, 0, 2, 0, 0));
        vecs[16] = mk(4'h6, 0, 1, pk(0, 3, 0, 0, 0, 2, 0, 0));
        vecs[17] = mk(4'h6, 0, 0, pk(1, 3, 1, 1, 0, 2, 0, 0));
        vecs[18] = mk(4'h6, 0, 1, pk(0, 3, 1, 1, 0, 2, 0, 0));
        vecs[19] = mk(4'h6, 0, 0, pk(1, 3, 3, 3, 0, 2, 0, 0));
        vecs[20] = mk(4'h6, 0, 1, pk(0, 3, 3, 3, 0, 2, 0, 0));
        vecs[21] = mk(4'hf, 0, 0, pk(1, 3, 5, 5, 0, 3, 1, 1));
        vecs[22] = mk(4'hf, 0, 1, pk(0, 3, 5, 5, 0, 3, 1, 1));
        vecs[23] = mk(4'h1, 0, 0, pk(0, 3, 5, 5, 0, 3, 1, 1));
        vecs[24] = mk(4'h0, 1, 0, pk(0, 3, 5, 5, 0, 3, 1, 1));
        vecs[25] = mk(4'h0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs[26] = mk(4'h0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        check("reset_state", pk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            cycle(vecs[k].press, vecs[k].frc, vecs[k].ack);
            check($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Reach RACE with a frame outstanding, then pull reset mid-handshake.
        cycle(4'h1, 0, 0);
        cycle(4'h0, 0, 0);
        check("countdown_frame", pk(1, 0, 0, 0, 0, 1, 0, 0));
        cycle(4'h0, 0, 1);
        cycle(4'h0, 0, 0);
        cycle(4'h0, 0, 0);
        cycle(4'h0, 0, 0);
        check("race_frame", pk(1, 0, 0, 0, 0, 2, 0, 0));
        cycle(4'h1, 0, 0);
        check("race_req_held", pk(1, 0, 0, 0, 0, 2, 0, 0));

        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", pk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'h0, 0, 1);
        check("clearing_frame", pk(1, 0, 0, 0, 0, 0, 0, 0));
        cycle(4'h0, 0, 0);
        check("stale_ack_ignored", pk(1, 0, 0, 0, 0, 0, 0, 0));
        cycle(4'h0, 0, 1);
        check("clearing_ack", pk(0, 0, 0, 0, 0, 0, 0, 0));
        cycle(4'h0, 0, 0);
        check("idle_quiet", pk(0, 0, 0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
